fft_frame_ctrl: RTL

Per-chirp frame sequencer for the FMCW receive chain. It aligns sample capture to the synthesizer ramp start and discards the settling samples. It then writes exactly N decimated FIR samples into the FIR→FFT FIFO and bursts them into the FFT as one contiguous N-cycle block. Finally it gates the FFT output into the USB write path, dropping whole frames rather than sending partial ones when the USB path lacks room.

---
 rtl/fft_frame_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: per-chirp sequencer that settles, captures N FIR samples,
// bursts them into the FFT and gates the FFT result into the USB path.
module fft_frame_ctrl #(
  parameter int N              = 1024,
  parameter int N_WIDTH        = $clog2(N),
  parameter int SETTLE_SAMPLES = 16,
  parameter int DRAIN_TIMEOUT  = 8192,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 chirp_start_i,
  input  logic                 sample_valid_i,
  input  logic                 tx_space_i,
  input  logic                 fft_valid_i,
  input  logic [N_WIDTH-1:0]   fft_ctr_i,
  output logic                 fifo_wren_o,
  output logic                 fifo_rden_o,
  output logic                 fifo_flush_o,
  output logic                 fft_en_o,
  output logic                 tx_en_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  localparam int TMAX =
    (SETTLE_SAMPLES > DRAIN_TIMEOUT) ?
    SETTLE_SAMPLES : DRAIN_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [N_WIDTH-1:0] LAST =
    N_WIDTH'(N - 1);
  localparam logic [TW-1:0] SET_LAST =
    TW'(SETTLE_SAMPLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, ACQ, LOAD, DRAIN, DROP
  } state_t;

  localparam state_t START =
    (SETTLE_SAMPLES == 0) ? ACQ : SETTLE;

  state_t state_q;
  state_t state_d;

  logic [N_WIDTH-1:0]   smp_q;
  logic [TW-1:0]        tmr_q;
  logic [CNT_WIDTH-1:0] frame_q;
  logic [CNT_WIDTH-1:0] drop_q;

  logic rden_q, flush_q, en_q, tx_q, busy_q;
  logic rden_d, flush_d, en_d, tx_d, busy_d;

  logic abort;
  logic last_wr;
  logic done;

  // A chirp during capture restarts the frame; its strobe is never written.
  assign abort = chirp_start_i &&
    (state_q == SETTLE || state_q == ACQ);

  assign fifo_wren_o = (state_q == ACQ) &&
    sample_valid_i && !chirp_start_i;

  assign last_wr = fifo_wren_o && (smp_q == LAST);
  assign done = fft_valid_i && (fft_ctr_i == LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rden_q  <= 1'b0;
      flush_q <= 1'b0;
      en_q    <= 1'b0;
      tx_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rden_q  <= rden_d;
      flush_q <= flush_d;
      en_q    <= en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (chirp_start_i) state_d = START;
      end
      SETTLE: begin
        if (abort) state_d = START;
        else if (sample_valid_i &&
                 tmr_q == SET_LAST)
          state_d = ACQ;
      end
      ACQ: begin
        if (abort) state_d = START;
        else if (last_wr)
          state_d = tx_space_i ? LOAD : DROP;
      end
      LOAD: begin
        if (smp_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (done) state_d = IDLE;
        else if (tmr_q == TO_LAST) state_d = DROP;
      end
      DROP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fft_en trails the state by one cycle so it lags rden and
  // stays up for one cycle after DRAIN to flush the FFT pipe.
  always_comb begin
    rden_d  = (state_d == LOAD);
    tx_d    = (state_d == DRAIN);
    busy_d  = (state_d != IDLE);
    flush_d = (state_d == DROP) || abort;
    en_d    = (state_q == LOAD) ||
              (state_q == DRAIN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      smp_q <= '0;
      tmr_q <= '0;
    end else if (abort || state_d != state_q) begin
      smp_q <= '0;
      tmr_q <= '0;
    end else begin
      if (fifo_wren_o || state_q == LOAD)
        smp_q <= smp_q + N_WIDTH'(1);
      if ((state_q == SETTLE && sample_valid_i) ||
          state_q == DRAIN)
        tmr_q <= tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      if (state_q == DRAIN && done)
        frame_q <= frame_q + CNT_WIDTH'(1);
      if (flush_d)
        drop_q <= drop_q + CNT_WIDTH'(1);
    end
  end

  assign fifo_rden_o  = rden_q;
  assign fifo_flush_o = flush_q;
  assign fft_en_o     = en_q;
  assign tx_en_o      = tx_q;
  assign busy_o       = busy_q;
  assign frame_cnt_o  = frame_q;
  assign drop_cnt_o   = drop_q;

endmodule
